// File: rtl/cpu_pkg.sv
// Shared CPU definitions: command opcodes, register-bank special selects and
// the stack sequencer state encoding.
package cpu_pkg;

    localparam logic [1:0] OP_PUSH = 2'd0;
    localparam logic [1:0] OP_POP  = 2'd1;
    localparam logic [1:0] OP_CALL = 2'd2;
    localparam logic [1:0] OP_RET  = 2'd3;

    localparam logic [3:0] SEL_SP  = 4'd8;
    localparam logic [3:0] SEL_ISR = 4'd9;

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_LD_SP   = 4'd1;
    localparam logic [3:0] ST_LD_SRC  = 4'd2;
    localparam logic [3:0] ST_MEM_WR  = 4'd3;
    localparam logic [3:0] ST_MEM_RD  = 4'd4;
    localparam logic [3:0] ST_MEM_CAP = 4'd5;
    localparam logic [3:0] ST_REG_WR  = 4'd6;
    localparam logic [3:0] ST_SP_WR   = 4'd7;
    localparam logic [3:0] ST_DONE    = 4'd8;

endpackage

// File: rtl/stack_unit.sv
// Stack sequencer: runs PUSH/POP/CALL/RET by mastering the register bank (SP via
// select 8) and the data memory. Downward-growing stack, SP points at the top word.
module stack_unit
    import cpu_pkg::*;
#(
    parameter logic [11:0] STACK_BASE  = 12'h000,
    parameter int          STACK_DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [2:0]  cmd_reg,
    input  logic [11:0] cmd_pc,
    output logic        done,
    output logic        fault,
    output logic [11:0] ret_pc,
    output logic [3:0]  rb_read_sel,
    input  logic [15:0] rb_read_data,
    output logic [3:0]  rb_write_sel,
    output logic        rb_write_en,
    output logic [15:0] rb_write_data,
    output logic [11:0] mem_addr,
    output logic        mem_we,
    output logic [15:0] mem_wdata,
    output logic        mem_re,
    input  logic [15:0] mem_rdata
);

    localparam logic [11:0] DEPTH_MAX = 12'(STACK_DEPTH);

    logic [3:0]  state;
    logic [3:0]  state_nxt;
    logic [1:0]  op_q;
    logic [2:0]  reg_q;
    logic [11:0] pc_q;
    logic [11:0] sp_q;
    logic [15:0] data_q;
    logic        fault_q;
    logic        push_like;
    logic        at_fault;
    logic [11:0] sp_next;

    function automatic logic [11:0] stack_depth(input logic [11:0] sp);
        return STACK_BASE - sp;
    endfunction

    assign push_like = (op_q == OP_PUSH) || (op_q == OP_CALL);
    assign at_fault  = push_like ? (stack_depth(rb_read_data[11:0]) == DEPTH_MAX)
                                 : (stack_depth(rb_read_data[11:0]) == 12'd0);
    assign sp_next   = push_like ? (sp_q - 12'd1) : (sp_q + 12'd1);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (cmd_valid) state_nxt = ST_LD_SP;
            ST_LD_SP: begin
                if (at_fault)       state_nxt = ST_DONE;
                else if (push_like) state_nxt = ST_LD_SRC;
                else                state_nxt = ST_MEM_RD;
            end
            ST_LD_SRC:  state_nxt = ST_MEM_WR;
            ST_MEM_WR:  state_nxt = ST_SP_WR;
            ST_MEM_RD:  state_nxt = ST_MEM_CAP;
            ST_MEM_CAP: state_nxt = ST_REG_WR;
            ST_REG_WR:  state_nxt = ST_SP_WR;
            ST_SP_WR:   state_nxt = ST_DONE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            fault_q <= 1'b0;
            ret_pc  <= 12'd0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && cmd_valid)
                fault_q <= 1'b0;
            if (state == ST_LD_SP)
                fault_q <= at_fault;
            if (state == ST_REG_WR && op_q == OP_RET)
                ret_pc <= data_q[11:0];
        end
    end

    // Datapath latches carry no reset: they are always reloaded before use.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && cmd_valid) begin
            op_q  <= cmd_op;
            reg_q <= cmd_reg;
            pc_q  <= cmd_pc;
        end
        if (state == ST_LD_SP)
            sp_q <= rb_read_data[11:0];
        if (state == ST_LD_SRC)
            data_q <= (op_q == OP_CALL) ? {4'd0, pc_q} : rb_read_data;
        if (state == ST_MEM_CAP)
            data_q <= mem_rdata;
    end

    always_comb begin
        rb_read_sel   = SEL_SP;
        rb_write_sel  = 4'd0;
        rb_write_en   = 1'b0;
        rb_write_data = 16'd0;
        mem_addr      = 12'd0;
        mem_we        = 1'b0;
        mem_wdata     = 16'd0;
        mem_re        = 1'b0;
        case (state)
            ST_LD_SRC: rb_read_sel = {1'b0, reg_q};
            ST_MEM_WR: begin
                mem_addr  = sp_q - 12'd1;
                mem_wdata = data_q;
                mem_we    = 1'b1;
            end
            ST_MEM_RD: begin
                mem_addr = sp_q;
                mem_re   = 1'b1;
            end
            ST_REG_WR: begin
                if (op_q == OP_POP) begin
                    rb_write_sel  = {1'b0, reg_q};
                    rb_write_data = data_q;
                    rb_write_en   = 1'b1;
                end
            end
            // SP goes last so an interrupted command never leaves it half-updated.
            ST_SP_WR: begin
                rb_write_sel  = SEL_SP;
                rb_write_data = {4'd0, sp_next};
                rb_write_en   = 1'b1;
            end
            default: ;
        endcase
    end

    assign cmd_ready = (state == ST_IDLE);
    assign done      = (state == ST_DONE);
    assign fault     = done & fault_q;

endmodule

// File: tb/tb_stack_unit.sv
// Randomised bench for stack_unit: register bank and data memory are modelled
// here, and a queue-based stack model predicts every cycle of each command.
module tb_stack_unit;
    import cpu_pkg::*;

    localparam logic [11:0] BASE  = 12'h000;
    localparam int          DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid, cmd_ready, done, fault;
    logic [1:0]  cmd_op;
    logic [2:0]  cmd_reg;
    logic [11:0] cmd_pc, ret_pc, mem_addr;
    logic [3:0]  rb_read_sel, rb_write_sel;
    logic [15:0] rb_read_data, rb_write_data, mem_wdata, mem_rdata;
    logic        rb_write_en, mem_we, mem_re;

    always #5 clk = ~clk;

    stack_unit #(.STACK_BASE(BASE), .STACK_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_reg(cmd_reg), .cmd_pc(cmd_pc),
        .done(done), .fault(fault), .ret_pc(ret_pc),
        .rb_read_sel(rb_read_sel), .rb_read_data(rb_read_data),
        .rb_write_sel(rb_write_sel), .rb_write_en(rb_write_en),
        .rb_write_data(rb_write_data),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_re(mem_re), .mem_rdata(mem_rdata)
    );

    // Environment: register bank (combinational read) and 1-cycle-latency memory.
    logic [15:0] rb  [0:15];
    logic [15:0] mem [0:4095];
    logic        tb_we;
    logic [3:0]  tb_sel;
    logic [15:0] tb_data;

    assign rb_read_data = rb[rb_read_sel];

    always @(posedge clk) begin
        if (rb_write_en)  rb[rb_write_sel] <= rb_write_data;
        else if (tb_we)   rb[tb_sel] <= tb_data;
        if (mem_we)       mem[mem_addr] <= mem_wdata;
        if (mem_re)       mem_rdata <= mem[mem_addr];
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: stack as a queue (front = top), SP derived from its size.
    logic [15:0] m_regs [0:7];
    logic [15:0] m_stack [$];
    logic [11:0] m_ret_pc;

    function automatic logic [11:0] m_sp();
        return BASE - 12'(m_stack.size());
    endfunction

    typedef struct {
        logic        ready, done, fault, we, re, rbwe, chk_rsel, chk_ret;
        logic [11:0] addr, ret;
        logic [15:0] wdata, rbwdata;
        logic [3:0]  wsel, rsel;
    } cyc_t;

    cyc_t trace [$];
    bit   chk_en = 1'b0;

    function automatic cyc_t blank(input logic rdy);
        cyc_t c;
        c.ready = rdy; c.done = 0; c.fault = 0; c.we = 0; c.re = 0; c.rbwe = 0;
        c.chk_rsel = 0; c.chk_ret = 0; c.addr = 0; c.ret = 0; c.wdata = 0;
        c.rbwdata = 0; c.wsel = 0; c.rsel = 0;
        return c;
    endfunction

    // Build the expected per-cycle behaviour of one command (cycle 0 = accept) and update the model.
    task automatic plan(input logic [1:0] op, input logic [2:0] r, input logic [11:0] pc, output int len);
        cyc_t        c;
        logic [11:0] sp;
        logic [15:0] w;
        bit          push, flt;
        sp   = m_sp();
        push = (op == OP_PUSH) || (op == OP_CALL);
        flt  = push ? (m_stack.size() == DEPTH) : (m_stack.size() == 0);
        trace.push_back(blank(1'b1));
        c = blank(1'b0); c.chk_rsel = 1; c.rsel = SEL_SP; trace.push_back(c);
        if (!flt && push) begin
            w = (op == OP_PUSH) ? m_regs[r] : {4'd0, pc};
            c = blank(1'b0); c.chk_rsel = 1; c.rsel = {1'b0, r}; trace.push_back(c);
            c = blank(1'b0); c.we = 1; c.addr = sp - 12'd1; c.wdata = w; trace.push_back(c);
            c = blank(1'b0); c.rbwe = 1; c.wsel = SEL_SP; c.rbwdata = {4'd0, sp - 12'd1}; trace.push_back(c);
            m_stack.push_front(w);
        end else if (!flt) begin
            w = m_stack.pop_front();
            c = blank(1'b0); c.re = 1; c.addr = sp; trace.push_back(c);
            trace.push_back(blank(1'b0));
            c = blank(1'b0);
            if (op == OP_POP) begin
                c.rbwe = 1; c.wsel = {1'b0, r}; c.rbwdata = w; m_regs[r] = w;
            end else begin
                m_ret_pc = w[11:0];
            end
            trace.push_back(c);
            c = blank(1'b0); c.rbwe = 1; c.wsel = SEL_SP; c.rbwdata = {4'd0, sp + 12'd1}; trace.push_back(c);
        end
        c = blank(1'b0); c.done = 1; c.fault = flt; c.chk_ret = 1; c.ret = m_ret_pc;
        trace.push_back(c);
        len = trace.size();
    endtask

    always @(negedge clk) begin
        cyc_t e;
        if (chk_en) begin
            if (trace.size() > 0) e = trace.pop_front();
            else                  e = blank(1'b1);
            check("cmd_ready", cmd_ready, e.ready);
            check("done", done, e.done);
            check("mem_we", mem_we, e.we);
            check("mem_re", mem_re, e.re);
            check("rb_write_en", rb_write_en, e.rbwe);
            if (e.done)     check("fault", fault, e.fault);
            if (e.chk_ret)  check("ret_pc_at_done", ret_pc, e.ret);
            if (e.chk_rsel) check("rb_read_sel", rb_read_sel, e.rsel);
            if (e.we) begin
                check("mem_addr_wr", mem_addr, e.addr);
                check("mem_wdata", mem_wdata, e.wdata);
            end
            if (e.re)       check("mem_addr_rd", mem_addr, e.addr);
            if (e.rbwe) begin
                check("rb_write_sel", rb_write_sel, e.wsel);
                check("rb_write_data", rb_write_data, e.rbwdata);
            end
        end
    end

    task automatic post_check();
        check("sp_reg", rb[SEL_SP], {4'd0, m_sp()});
        for (int i = 0; i < 8; i++)
            check($sformatf("r%0d", i), rb[i], m_regs[i]);
        check("ret_pc", ret_pc, m_ret_pc);
    endtask

    task automatic set_reg(input logic [3:0] r, input logic [15:0] v);
        @(posedge clk); #1;
        tb_we = 1'b1; tb_sel = r; tb_data = v;
        @(posedge clk); #1;
        tb_we = 1'b0;
        if (r < 4'd8) m_regs[r[2:0]] = v;
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [2:0] r, input logic [11:0] pc, input bit noise);
        int len;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = op; cmd_reg = r; cmd_pc = pc;
        plan(op, r, pc, len);
        @(posedge clk); #1;
        if (noise) begin
            cmd_valid = 1'b1; cmd_op = 2'($urandom); cmd_reg = 3'($urandom); cmd_pc = 12'($urandom);
        end else begin
            cmd_valid = 1'b0;
        end
        repeat (len - 2) @(posedge clk);
        #1 cmd_valid = 1'b0;
        post_check();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    initial begin
        cmd_valid = 0; cmd_op = 0; cmd_reg = 0; cmd_pc = 0;
        tb_we = 0; tb_sel = 0; tb_data = 0;
        m_ret_pc = 12'd0;
        #1 rst = 1'b0;
        #2;
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_done", done, 1'b0);
        check("rst_fault", fault, 1'b0);
        check("rst_ret_pc", ret_pc, 12'd0);
        check("rst_strobes", {mem_we, mem_re, rb_write_en}, 3'b000);
        check("rst_mem_addr", mem_addr, 12'd0);
        check("rst_rb_wdata", rb_write_data, 16'd0);
        check("rst_rb_read_sel", rb_read_sel, 4'd8);
        check("rst_rb_write_sel", rb_write_sel, 4'd0);
        for (int i = 0; i < 16; i++)
            set_reg(4'(i), (i == 8) ? {4'd0, BASE} : 16'($urandom));
        @(negedge clk) rst = 1'b1;
        #1 chk_en = 1'b1;

        // PUSH R3 = BEEF then POP into R5
        set_reg(4'd3, 16'hBEEF);
        run_cmd(OP_PUSH, 3'd3, 12'd0, 1'b0);
        check("lit_push_mem", mem[12'hFFF], 16'hBEEF);
        check("lit_push_sp", rb[8], 16'h0FFF);
        run_cmd(OP_POP, 3'd5, 12'd0, 1'b1);
        check("lit_pop_r5", rb[5], 16'hBEEF);
        check("lit_pop_sp", rb[8], 16'h0000);

        // Underflow, then overflow at depth 2
        run_cmd(OP_POP, 3'd1, 12'd0, 1'b0);
        check("lit_underflow_sp", rb[8], 16'h0000);
        run_cmd(OP_PUSH, 3'd0, 12'd0, 1'b0);
        run_cmd(OP_PUSH, 3'd7, 12'd0, 1'b1);
        run_cmd(OP_PUSH, 3'd2, 12'd0, 1'b0);
        check("lit_overflow_sp", rb[8], 16'h0FFE);
        run_cmd(OP_POP, 3'd4, 12'd0, 1'b0);
        run_cmd(OP_POP, 3'd6, 12'd0, 1'b0);

        // CALL / RET round trip
        run_cmd(OP_CALL, 3'd0, 12'h123, 1'b0);
        check("lit_call_mem", mem[12'hFFF], 16'h0123);
        run_cmd(OP_RET, 3'd0, 12'd0, 1'b0);
        check("lit_ret_pc", ret_pc, 12'h123);
        check("lit_ret_sp", rb[8], 16'h0000);

        // Reset during MEM_WR of a PUSH
        run_cmd(OP_PUSH, 3'd2, 12'd0, 1'b0);
        @(posedge clk); #1;
        chk_en = 1'b0;
        cmd_valid = 1'b1; cmd_op = OP_PUSH; cmd_reg = 3'd1; cmd_pc = 12'd0;
        @(posedge clk); #1 cmd_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("midrst_mem_we_before", mem_we, 1'b1);
        check("midrst_addr_before", mem_addr, 12'hFFE);
        #1 rst = 1'b0;
        #1;
        check("midrst_strobes", {mem_we, mem_re, rb_write_en}, 3'b000);
        check("midrst_mem_addr", mem_addr, 12'd0);
        check("midrst_cmd_ready", cmd_ready, 1'b1);
        check("midrst_done", done, 1'b0);
        check("midrst_rb_read_sel", rb_read_sel, 4'd8);
        @(negedge clk) rst = 1'b1;
        m_ret_pc = 12'd0;
        trace.delete();
        #1 chk_en = 1'b1;
        check("midrst_sp", rb[8], 16'h0FFF);
        run_cmd(OP_POP, 3'd6, 12'd0, 1'b0);

        // Randomised traffic
        for (int k = 0; k < 300; k++) begin
            idle(int'($urandom_range(0, 2)));
            if ($urandom_range(0, 3) == 0)
                set_reg({1'b0, 3'($urandom)}, 16'($urandom));
            run_cmd(2'($urandom), 3'($urandom), 12'($urandom), 1'($urandom));
        end

        idle(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
